// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix-keypad scanner and its display decode.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StPressDb,
        StPressed,
        StRelDb
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // abcdefg, a = MSB; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-high abcdefg decode; codes above 15 blank the display.
module hex_to_7seg
    import keypad_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] code,
    output logic [6:0]   seg
);

    logic [31:0] code_wide;

    always_comb begin
        code_wide = 32'(code);
        seg       = SEG_BLANK;
        if (code_wide < 32'd16) begin
            seg = SEG_HEX[code_wide[3:0]];
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix-keypad scanner: one-hot row strobe, single-hit column sampling once per slot,
// press/release debounce, registered key code, valid pulse, held level and 7-seg pattern.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_ROWS       = 4,
    parameter int unsigned NUM_COLS       = 4,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned CODE_W         = $clog2(NUM_ROWS * NUM_COLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] col_line,
    output logic [NUM_ROWS-1:0] row_line,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_held,
    output logic [6:0]          seg
);

    localparam int unsigned ROW_W = $clog2(NUM_ROWS);
    localparam int unsigned COL_W = $clog2(NUM_COLS);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    state_e              state;
    logic [DIV_W-1:0]    div;
    logic [CNT_W-1:0]    cnt;
    logic [ROW_W-1:0]    row_idx;
    logic [COL_W-1:0]    cap_col;

    logic                tick;
    logic                hit;
    int unsigned         hit_cnt;
    logic [COL_W-1:0]    hit_col;
    logic [ROW_W-1:0]    row_inc;
    logic [NUM_ROWS-1:0] row_inc_oh;
    logic [CODE_W-1:0]   new_code;
    logic [6:0]          new_seg;

    assign tick = (div == DIV_W'(SCAN_DIV - 1));

    // A hit needs exactly one closed column; multi-column samples are ghosting.
    always_comb begin
        hit_cnt = 0;
        hit_col = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (col_line[i]) begin
                hit_cnt = hit_cnt + 1;
                hit_col = COL_W'(i);
            end
        end
        hit = (hit_cnt == 1);
    end

    always_comb begin
        row_inc    = (row_idx == ROW_W'(NUM_ROWS - 1)) ? '0 : row_idx + ROW_W'(1);
        row_inc_oh = NUM_ROWS'(1) << row_inc;
    end

    // Row is locked while debouncing, so row_idx is the captured row.
    assign new_code = CODE_W'(row_idx) * CODE_W'(NUM_COLS) + CODE_W'(hit_col);

    hex_to_7seg #(
        .W(CODE_W)
    ) u_hex_to_7seg (
        .code(new_code),
        .seg (new_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StScan;
            div       <= '0;
            cnt       <= '0;
            row_idx   <= '0;
            cap_col   <= '0;
            row_line  <= NUM_ROWS'(1);
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            seg       <= SEG_BLANK;
        end else begin
            key_valid <= 1'b0;
            div       <= tick ? '0 : div + DIV_W'(1);
            if (tick) begin
                unique case (state)
                    StScan: begin
                        if (hit) begin
                            cap_col <= hit_col;
                            cnt     <= CNT_W'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                state     <= StPressed;
                                key_code  <= new_code;
                                seg       <= new_seg;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                state <= StPressDb;
                            end
                        end else begin
                            row_idx  <= row_inc;
                            row_line <= row_inc_oh;
                        end
                    end
                    StPressDb: begin
                        if (hit && hit_col == cap_col) begin
                            if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                                state     <= StPressed;
                                key_code  <= new_code;
                                seg       <= new_seg;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else begin
                            state    <= StScan;
                            row_idx  <= row_inc;
                            row_line <= row_inc_oh;
                        end
                    end
                    StPressed: begin
                        if (!col_line[cap_col]) begin
                            cnt <= CNT_W'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                state    <= StScan;
                                key_held <= 1'b0;
                                row_idx  <= row_inc;
                                row_line <= row_inc_oh;
                            end else begin
                                state <= StRelDb;
                            end
                        end
                    end
                    StRelDb: begin
                        if (!col_line[cap_col]) begin
                            if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                                state    <= StScan;
                                key_held <= 1'b0;
                                row_idx  <= row_inc;
                                row_line <= row_inc_oh;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else begin
                            state <= StPressed;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: directed key presses push expected reports,
// a monitor pops and compares on every key_valid.
module tb_keypad_scan_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] col_line;
    logic [3:0] row_line;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [6:0] seg;

    typedef struct packed {
        logic [3:0] code;
        logic [6:0] seg;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic       key_down = 1'b0;
    int         key_r = 0;
    int         key_c = 0;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'b0000;
    logic       prev_valid = 1'b0;

    keypad_scan_ctrl #(
        .NUM_ROWS      (4),
        .NUM_COLS      (4),
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col_line (col_line),
        .row_line (row_line),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a closed key shorts its column only while its row is strobed.
    always_comb begin
        col_line = 4'b0000;
        if (force_en) begin
            col_line = force_val;
        end else if (key_down && row_line[key_r]) begin
            col_line[key_c] = 1'b1;
        end
    end

    function automatic logic [6:0] exp_seg(input int code);
        case (code)
            0:  return 7'b1111110;
            1:  return 7'b0110000;
            2:  return 7'b1101101;
            3:  return 7'b1111001;
            4:  return 7'b0110011;
            5:  return 7'b1011011;
            6:  return 7'b1011111;
            7:  return 7'b1110000;
            8:  return 7'b1111111;
            9:  return 7'b1111011;
            10: return 7'b1110111;
            11: return 7'b0011111;
            12: return 7'b1001110;
            13: return 7'b0111101;
            14: return 7'b1001111;
            15: return 7'b1000111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_held(input logic lvl, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_held === lvl) break;
        end
        chk("held_wait", 32'(key_held), 32'(lvl));
    endtask

    task automatic wait_row(input logic [3:0] row, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (row_line === row) break;
        end
        chk("row_wait", 32'(row_line), 32'(row));
    endtask

    task automatic press(input int r, input int c);
        exp_t e;
        e.code = 4'(r * 4 + c);
        e.seg  = exp_seg(r * 4 + c);
        exp_q.push_back(e);
        key_r    = r;
        key_c    = c;
        key_down = 1'b1;
    endtask

    // Monitor: every accepted key must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (prev_valid) chk("valid_width", 32'(key_valid), 32'd0);
        if (key_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got code %0d expected no report", key_code);
            end else begin
                e = exp_q.pop_front();
                chk("key_code", 32'(key_code), 32'(e.code));
                chk("seg", 32'(seg), 32'(e.seg));
                chk("held_at_valid", 32'(key_held), 32'd1);
            end
        end
        prev_valid <= key_valid;
    end

    int key_list[8][2] = '{'{0, 0}, '{3, 3}, '{3, 2}, '{0, 3},
                           '{2, 2}, '{1, 1}, '{2, 3}, '{1, 0}};

    initial begin
        int         lat;
        logic [3:0] seen;
        logic [3:0] one;
        rst = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_row", 32'(row_line), 32'b0001);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);
        chk("rst_seg", 32'(seg), 32'd0);
        rst = 1'b0;

        // Idle rotation, 4 cycles per row
        one = 4'b0001;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge clk);
            chk("idle_row", 32'(row_line), 32'(one << ((k / 4) % 4)));
        end

        // Stable press at row 2 col 1 -> code 9
        press(2, 1);
        wait_held(1'b1, 200);
        chk("lock_row", 32'(row_line), 32'b0100);
        key_down = 1'b0;
        wait_held(1'b0, 200);
        chk("resume_row", 32'(row_line), 32'b1000);
        chk("code_hold", 32'(key_code), 32'd9);
        chk("seg_hold", 32'(seg), 32'b1111011);

        // Press bounce: two matching ticks, then gone
        key_r = 2;
        key_c = 1;
        key_down = 1'b1;
        wait_row(4'b0100, 100);
        repeat (8) @(negedge clk);
        key_down = 1'b0;
        repeat (3) @(negedge clk);
        chk("bounce_lock", 32'(row_line), 32'b0100);
        @(negedge clk);
        chk("bounce_row", 32'(row_line), 32'b1000);
        chk("bounce_held", 32'(key_held), 32'd0);

        // Release glitch: one clear tick must not release or re-report
        press(1, 3);
        wait_held(1'b1, 200);
        key_down = 1'b0;
        repeat (4) @(negedge clk);
        key_down = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_held", 32'(key_held), 32'd1);
        chk("glitch_row", 32'(row_line), 32'b0010);
        key_down = 1'b0;
        wait_held(1'b0, 200);
        chk("glitch_resume", 32'(row_line), 32'b0100);

        // Ghosting: two columns never count as a hit
        force_val = 4'b0011;
        force_en  = 1'b1;
        seen      = 4'b0000;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            seen = seen | row_line;
        end
        chk("ghost_held", 32'(key_held), 32'd0);
        chk("ghost_rotate", 32'(seen), 32'b1111);
        force_en = 1'b0;

        // Assorted keys and display patterns
        for (int i = 0; i < 8; i++) begin
            press(key_list[i][0], key_list[i][1]);
            wait_held(1'b1, 300);
            chk("key_row", 32'(row_line), 32'(one << key_list[i][0]));
            key_down = 1'b0;
            wait_held(1'b0, 300);
            chk("key_code_after", 32'(key_code), 32'(key_list[i][0] * 4 + key_list[i][1]));
        end

        // Reset while pressed, key stays down
        press(2, 1);
        wait_held(1'b1, 300);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_held", 32'(key_held), 32'd0);
        chk("mid_rst_row", 32'(row_line), 32'b0001);
        chk("mid_rst_code", 32'(key_code), 32'd0);
        chk("mid_rst_seg", 32'(seg), 32'd0);
        press(2, 1);
        rst = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (key_valid) begin
                lat = k;
                break;
            end
        end
        chk("reaccept_latency", 32'(lat), 32'd20);
        key_down = 1'b0;
        wait_held(1'b0, 300);

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
